// File: rtl/vga_timing_gen_if.sv
// Control and pixel-output bundle of the VGA timing generator.
// master drives scroll/pattern control; slave is the generator itself.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [X_W-1:0] scroll_x_in;
    logic [Y_W-1:0] scroll_y_in;
    logic           scroll_we;
    logic [1:0]     pattern_mode;
    logic [4:0]     vga_red;
    logic [5:0]     vga_green;
    logic [4:0]     vga_blue;
    logic           vga_hsync;
    logic           vga_vsync;
    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic           pixel_valid;
    logic           line_start;
    logic           frame_start;

    modport master (
        output scroll_x_in, scroll_y_in, scroll_we, pattern_mode,
        input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync,
        input  pixel_x, pixel_y, pixel_valid, line_start, frame_start
    );

    modport slave (
        input  scroll_x_in, scroll_y_in, scroll_we, pattern_mode,
        output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync,
        output pixel_x, pixel_y, pixel_valid, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered RGB565 test patterns,
// frame-synchronous scrolling and pixel/line/frame strobes. Needs X_W >= 9, Y_W >= 5.
module vga_timing_gen #(
    parameter int CLKS_PER_PIXEL = 4,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter bit HSYNC_POL      = 1'b0,
    parameter bit VSYNC_POL      = 1'b0,
    parameter int X_W            = 10,
    parameter int Y_W            = 9
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.slave bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW       = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [DW-1:0]  div_q, div_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [X_W-1:0] pend_x_q, pend_x_d, scr_x_q, scr_x_d;
    logic [Y_W-1:0] pend_y_q, pend_y_d, scr_y_q, scr_y_d;

    logic [4:0]     red_q, red_d, blue_q, blue_d;
    logic [5:0]     green_q, green_d;
    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic [X_W-1:0] pixel_x_q, pixel_x_d;
    logic [Y_W-1:0] pixel_y_q, pixel_y_d;
    logic           pixel_valid_q, pixel_valid_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;

    logic           div_wrap, h_wrap, v_wrap, frame_wrap;
    logic           active, hs_on, vs_on;
    logic [2:0]     bar_idx;
    logic [X_W-1:0] h_ext;
    logic [Y_W-1:0] v_ext;

    // Counters resized to the coordinate field width before the scroll add.
    if (HW >= X_W) begin : g_hx
        assign h_ext = h_q[X_W-1:0];
    end else begin : g_hx
        assign h_ext = {{(X_W-HW){1'b0}}, h_q};
    end
    if (VW >= Y_W) begin : g_vy
        assign v_ext = v_q[Y_W-1:0];
    end else begin : g_vy
        assign v_ext = {{(Y_W-VW){1'b0}}, v_q};
    end

    always_comb begin
        div_wrap   = (div_q == DW'(CLKS_PER_PIXEL - 1));
        h_wrap     = (h_q == HW'(H_TOTAL - 1));
        v_wrap     = (v_q == VW'(V_TOTAL - 1));
        frame_wrap = div_wrap && h_wrap && v_wrap;

        div_d = div_wrap ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (div_wrap) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap)
                v_d = v_wrap ? '0 : v_q + 1'b1;
        end

        // A write landing on the wrap clock bypasses pending and takes effect at once.
        pend_x_d = bus.scroll_we ? bus.scroll_x_in : pend_x_q;
        pend_y_d = bus.scroll_we ? bus.scroll_y_in : pend_y_q;
        scr_x_d  = scr_x_q;
        scr_y_d  = scr_y_q;
        if (frame_wrap) begin
            scr_x_d = bus.scroll_we ? bus.scroll_x_in : pend_x_q;
            scr_y_d = bus.scroll_we ? bus.scroll_y_in : pend_y_q;
        end
    end

    always_comb begin
        active = ({1'b0, h_q} < (HW+1)'(H_ACTIVE)) && ({1'b0, v_q} < (VW+1)'(V_ACTIVE));
        hs_on  = ({1'b0, h_q} >= (HW+1)'(HS_START)) && ({1'b0, h_q} < (HW+1)'(HS_END));
        vs_on  = ({1'b0, v_q} >= (VW+1)'(VS_START)) && ({1'b0, v_q} < (VW+1)'(VS_END));

        pixel_x_d     = scr_x_q + h_ext;
        pixel_y_d     = scr_y_q + v_ext;
        hsync_d       = hs_on ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = vs_on ? VSYNC_POL : ~VSYNC_POL;
        pixel_valid_d = active && (div_q == '0);
        line_start_d  = (div_q == '0) && (h_q == '0);
        frame_start_d = line_start_d && (v_q == '0);

        bar_idx = pixel_x_d[8:6];
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (active) begin
            case (bus.pattern_mode)
                2'd1: if (pixel_x_d[3]) begin
                    red_d   = 5'h1F;
                    green_d = 6'h2A;
                end
                2'd2: if (pixel_x_d[4] ^ pixel_y_d[4]) begin
                    red_d   = 5'h1F;
                    green_d = 6'h3F;
                    blue_d  = 5'h1F;
                end
                2'd3: begin
                    red_d   = bar_idx[2] ? 5'h1F : 5'h00;
                    green_d = bar_idx[1] ? 6'h3F : 6'h00;
                    blue_d  = bar_idx[0] ? 5'h1F : 5'h00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            scr_x_q       <= '0;
            scr_y_q       <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_valid_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            scr_x_q       <= scr_x_d;
            scr_y_q       <= scr_y_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_valid_q <= pixel_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.vga_red     = red_q;
    assign bus.vga_green   = green_q;
    assign bus.vga_blue    = blue_q;
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.pixel_x     = pixel_x_q;
    assign bus.pixel_y     = pixel_y_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
endmodule
